// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter sending start, DATA_BITS LSB-first,
// optional parity and 1/2 stop bits, with back-to-back frames while words are queued.
module uart_tx_fifo #(
    parameter int CLK_PERIOD_NS = 50,
    parameter int BAUD_RATE     = 9600,
    parameter int DATA_BITS     = 7,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_BITS-1:0]        tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int CLKS_PER_BIT = 1_000_000_000 / (CLK_PERIOD_NS * BAUD_RATE);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = AW + 1;
    if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2) || CLKS_PER_BIT < 2 ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
        $error("uart_tx_fifo: illegal parameter set");
    end
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
    state_t               state;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wp, rp;
    logic [NW-1:0]        count_nx;
    logic [CW-1:0]        cnt;
    logic [3:0]           idx;
    logic [DATA_BITS-1:0] shift;
    logic                 par_bit, bit_end, last_stop, push, pop;
    assign bit_end   = cnt == CW'(CLKS_PER_BIT - 1);
    assign last_stop = state == STOP && bit_end && idx == 4'(STOP_BITS - 1);
    // The head is popped either from idle or at the very end of the last stop bit.
    assign pop       = fifo_count != '0 && (state == IDLE || last_stop);
    assign push      = tx_valid && tx_ready;
    assign count_nx  = fifo_count + NW'(push) - NW'(pop);
    always_ff @(posedge clk) if (push) mem[wp] <= tx_data;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wp         <= '0;
            rp         <= '0;
            fifo_count <= '0;
            tx_ready   <= 1'b1;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            fifo_count <= count_nx;
            tx_ready   <= count_nx < NW'(FIFO_DEPTH);
        end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shift   <= '0;
            par_bit <= 1'b0;
            tx      <= 1'b1;
            busy    <= 1'b0;
        end else begin
            cnt <= (pop || bit_end || state == IDLE) ? '0 : cnt + 1'b1;
            if (pop) begin
                state   <= START;
                shift   <= mem[rp];
                par_bit <= PARITY == 1 ? ~^mem[rp] : ^mem[rp];
                idx     <= '0;
                tx      <= 1'b0;
                busy    <= 1'b1;
            end else if (bit_end) begin
                case (state)
                    START: begin
                        state <= DATA;
                        idx   <= '0;
                        tx    <= shift[0];
                    end
                    DATA: if (idx == 4'(DATA_BITS - 1)) begin
                        state <= PARITY != 0 ? PAR : STOP;
                        idx   <= '0;
                        tx    <= PARITY != 0 ? par_bit : 1'b1;
                    end else begin
                        idx   <= idx + 1'b1;
                        shift <= shift >> 1;
                        tx    <= shift[1];
                    end
                    PAR: begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end
                    STOP: if (idx == 4'(STOP_BITS - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        idx   <= idx + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench; a line decoder per instance pops expected words from a
// shared queue, while the stimulus process checks handshake, timing and reset behaviour.
module tb_uart_tx_fifo;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    logic [6:0] d0 = '0, d1 = '0, d2 = '0;
    logic       v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
    logic       r0, r1, r2, tx0, tx1, tx2, b0, b1, b2;
    logic [2:0] c0, c1, c2;
    logic [2:0] line, busy_v;
    assign line   = {tx2, tx1, tx0};
    assign busy_v = {b2, b1, b0};
    int errs = 0, checks = 0;
    typedef struct {int k; logic [6:0] d; logic p;} exp_t;
    exp_t q[$];
    // u0: 7N1 at 2083 clks/bit; u1: 7E2 at 10 clks/bit; u2: 7O1 at 10 clks/bit
    uart_tx_fifo u0 (.clk(clk), .rst(rst), .tx_data(d0), .tx_valid(v0), .tx_ready(r0),
                     .tx(tx0), .busy(b0), .fifo_count(c0));
    uart_tx_fifo #(.BAUD_RATE(2_000_000), .PARITY(2), .STOP_BITS(2)) u1 (
        .clk(clk), .rst(rst), .tx_data(d1), .tx_valid(v1), .tx_ready(r1),
        .tx(tx1), .busy(b1), .fifo_count(c1));
    uart_tx_fifo #(.BAUD_RATE(2_000_000), .PARITY(1)) u2 (
        .clk(clk), .rst(rst), .tx_data(d2), .tx_valid(v2), .tx_ready(r2),
        .tx(tx2), .busy(b2), .fifo_count(c2));

    function automatic int cpb(int k); return k == 0 ? 2083 : 10; endfunction
    function automatic int nbits(int k); return k == 0 ? 9 : (k == 1 ? 11 : 10); endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int k, input logic [6:0] d, input logic p);
        exp_t e;
        e.k = k; e.d = d; e.p = p;
        q.push_back(e);
    endtask

    task automatic wait_low(input int k, input int limit, output int n);
        n = 0;
        while (busy_v[k] && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic check_frame(input int k, input logic [10:0] fr);
        exp_t e;
        int   ef, nb;
        nb = nbits(k);
        if (q.size() == 0) begin
            chk("frame_unexpected", k, -1);
            return;
        end
        e  = q.pop_front();
        ef = int'(e.d) << 1;
        if (k != 0) ef |= int'(e.p) << 8;
        for (int j = (k == 0 ? 8 : 9); j < nb; j++) ef |= 1 << j;
        chk("frame", (k << 16) | (int'(fr) & ((1 << nb) - 1)), (e.k << 16) | ef);
    endtask

    int         t_m [3] = '{0, 0, 0};
    logic       act_m [3] = '{1'b0, 1'b0, 1'b0};
    logic [10:0] fr_m [3];
    logic [2:0] prev_m = 3'b111;
    initial forever begin
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            if (rst) act_m[k] = 1'b0;
            else if (act_m[k]) begin
                t_m[k]++;
                if (t_m[k] % cpb(k) == cpb(k) / 2) begin
                    fr_m[k][t_m[k] / cpb(k)] = line[k];
                    if (t_m[k] / cpb(k) == nbits(k) - 1) begin
                        act_m[k] = 1'b0;
                        check_frame(k, fr_m[k]);
                    end
                end
            end else if (prev_m[k] && !line[k]) begin
                act_m[k] = 1'b1;
                t_m[k]   = 0;
            end
            prev_m[k] = line[k];
        end
    end

    logic [6:0] w4 [6] = '{7'h01, 7'h03, 7'h7F, 7'h2A, 7'h66, 7'h40};
    logic       p4 [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    int         cnt4 [5] = '{1, 1, 2, 3, 4};
    initial begin
        int n, m;
        // reset and idle
        repeat (3) tick();
        chk("rst_hold", {tx0, r0, b0, c0}, 6'b110000);
        rst = 1'b0;
        repeat (5) begin
            tick();
            chk("idle_after_rst", {tx0, r0, b0, c0}, 6'b110000);
        end
        #3 rst = 1'b1;
        #1 chk("rst_mid_idle", {tx0, r0, b0, c0}, 6'b110000);
        tick();
        tick();
        rst = 1'b0;
        repeat (3) begin
            tick();
            chk("idle_after_rst2", {tx0, r0, b0, c0}, 6'b110000);
        end
        // default frame, 7'h55
        d0 = 7'h55; v0 = 1'b1; put(0, 7'h55, 1'b0);
        tick();
        v0 = 1'b0;
        chk("t2_accept", {tx0, b0, c0}, 5'b10001);
        tick();
        chk("t2_tx_fall", {tx0, b0, c0}, 5'b01000);
        wait_low(0, 20000, n);
        chk("t2_frame_len", n, 9 * 2083);
        // parity and two stop bits
        d1 = 7'h07; v1 = 1'b1; put(1, 7'h07, 1'b1);
        tick();
        v1 = 1'b0;
        tick();
        chk("t3_even_tx_fall", tx1, 0);
        wait_low(1, 500, n);
        chk("t3_even_2stop_len", n, 110);
        d2 = 7'h07; v2 = 1'b1; put(2, 7'h07, 1'b0);
        tick();
        v2 = 1'b0;
        tick();
        chk("t3_odd_tx_fall", tx2, 0);
        wait_low(2, 500, n);
        chk("t3_odd_len", n, 100);
        repeat (5) tick();
        // five words on consecutive clocks, sixth stalled, all back-to-back
        for (int i = 0; i < 5; i++) begin
            d2 = w4[i]; v2 = 1'b1; put(2, w4[i], p4[i]);
            tick();
            chk("t4_count", {r2, c2}, {cnt4[i] < 4, 3'(cnt4[i])});
        end
        d2 = w4[5]; put(2, w4[5], p4[5]);
        n = 3;
        while (!r2 && n < 200) begin
            tick();
            n++;
        end
        chk("t4_ready_rise", n, 100);
        tick();
        n++;
        v2 = 1'b0;
        chk("t4_sixth_accept", {r2, c2}, 4'b0100);
        wait_low(2, 1000, m);
        chk("t4_back_to_back_len", n + m, 600);
        repeat (5) tick();
        // push and pop on the same edge
        d2 = 7'h0F; v2 = 1'b1; put(2, 7'h0F, 1'b1);
        tick();
        d2 = 7'h70; put(2, 7'h70, 1'b0);
        tick();
        d2 = 7'h12; put(2, 7'h12, 1'b1);
        tick();
        v2 = 1'b0;
        repeat (98) tick();
        chk("t5_before", {b2, c2}, 4'b1010);
        d2 = 7'h35; v2 = 1'b1; put(2, 7'h35, 1'b1);
        tick();
        v2 = 1'b0;
        chk("t5_push_pop", {b2, tx2, r2, c2}, 6'b101010);
        wait_low(2, 1000, n);
        chk("t5_rest_len", n, 300);
        repeat (5) tick();
        // reset during data bit 3
        d2 = 7'h33; v2 = 1'b1;
        tick();
        v2 = 1'b0;
        tick();
        d2 = 7'h41; v2 = 1'b1;
        tick();
        v2 = 1'b0;
        chk("t6_queued", c2, 1);
        repeat (43) tick();
        chk("t6_bit3", {b2, tx2}, 2'b10);
        #2 rst = 1'b1;
        #1 chk("t6_async", {tx2, b2, c2, r2}, 6'b100001);
        tick();
        tick();
        rst = 1'b0;
        repeat (150) tick();
        chk("t6_quiet", {tx2, b2, c2, r2}, 6'b100001);
        d2 = 7'h5A; v2 = 1'b1; put(2, 7'h5A, 1'b1);
        tick();
        v2 = 1'b0;
        tick();
        chk("t6_next_tx_fall", tx2, 0);
        wait_low(2, 500, n);
        chk("t6_next_len", n, 100);
        repeat (20) tick();
        chk("sb_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
